// File: rtl/pipelined_alu.sv
// Registered ALU with valid/ready handshakes: single-cycle arithmetic/logic/shift ops
// plus an iterative signed shift-add multiply that runs for WIDTH cycles.
module pipelined_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic             err,
  output logic             dbg_state_o
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // the producer holds its payload until then, and out_* stay frozen while out_valid && !out_ready.

  typedef enum logic {IDLE = 1'b0, MUL_RUN = 1'b1} state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_NAND = 4'b0101;
  localparam logic [3:0] OP_NOR  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;

  localparam logic [SHAMT_W-1:0] CNT_ONE  = 1;
  localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);
  localparam logic [2*WIDTH-1:0] ONE_2W   = 1;
  localparam logic [WIDTH-1:0]   ONE_W    = 1;

  state_t               state_q, state_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d, err_q, err_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic                 neg_q, neg_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;

  logic                 accept, sub_op, add_ovf;
  logic [WIDTH-1:0]     b_eff, mag_a, mag_b, alu_res, mul_res;
  logic [WIDTH:0]       sum, step_sum;
  logic [SHAMT_W-1:0]   shamt;
  logic                 alu_carry, alu_ovf, alu_err, mul_ovf;
  logic [2*WIDTH-1:0]   prod_step, prod_signed;

  assign in_ready = rst_n && (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // One adder serves ADD, SUB and SLT; overflow is carry-in XOR carry-out of the MSB.
  assign sub_op  = (control == OP_SUB) || (control == OP_SLT);
  assign b_eff   = sub_op ? ~b : b;
  assign sum     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_op};
  assign add_ovf = a[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1] ^ sum[WIDTH];
  assign shamt   = b[SHAMT_W-1:0];

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_err   = 1'b0;
    case (control)
      OP_ADD, OP_SUB: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = add_ovf;
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
      OP_XOR:  alu_res = a ^ b;
      OP_AND:  alu_res = a & b;
      OP_NAND: alu_res = ~(a & b);
      OP_NOR:  alu_res = ~(a | b);
      OP_OR:   alu_res = a | b;
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $signed(a) >>> shamt;
      OP_MUL:  alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  // Magnitudes are WIDTH-bit unsigned, so the most-negative operand maps to 2^(WIDTH-1) exactly.
  assign mag_a = a[WIDTH-1] ? (~a + ONE_W) : a;
  assign mag_b = b[WIDTH-1] ? (~b + ONE_W) : b;

  // prod_q holds {partial sum, remaining multiplier bits}; each step adds then shifts right.
  assign step_sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_step   = {step_sum, prod_q[WIDTH-1:1]};
  assign prod_signed = neg_q ? (~prod_step + ONE_2W) : prod_step;
  assign mul_res     = prod_signed[WIDTH-1:0];
  assign mul_ovf     = prod_signed[2*WIDTH-1:WIDTH] != {WIDTH{prod_signed[WIDTH-1]}};

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    err_d       = err_q;
    prod_d      = prod_q;
    mcand_d     = mcand_q;
    neg_d       = neg_q;
    cnt_d       = cnt_q;
    if (accept) begin
      if (control == OP_MUL) begin
        state_d     = MUL_RUN;
        out_valid_d = 1'b0;
        prod_d      = {{WIDTH{1'b0}}, mag_b};
        mcand_d     = mag_a;
        neg_d       = a[WIDTH-1] ^ b[WIDTH-1];
        cnt_d       = '0;
      end else begin
        out_valid_d = 1'b1;
        result_d    = alu_res;
        carry_d     = alu_carry;
        ovf_d       = alu_ovf;
        zero_d      = (alu_res == '0);
        err_d       = alu_err;
      end
    end else if (state_q == MUL_RUN) begin
      prod_d = prod_step;
      cnt_d  = cnt_q + CNT_ONE;
      if (cnt_q == CNT_LAST) begin
        state_d     = IDLE;
        out_valid_d = 1'b1;
        result_d    = mul_res;
        carry_d     = 1'b0;
        ovf_d       = mul_ovf;
        zero_d      = (mul_res == '0);
        err_d       = 1'b0;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
      prod_q      <= '0;
      mcand_q     <= '0;
      neg_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
      prod_q      <= prod_d;
      mcand_q     <= mcand_d;
      neg_q       <= neg_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign carryout    = carry_q;
  assign overflow    = ovf_q;
  assign zero        = zero_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pipelined_alu.sv
// Bench for pipelined_alu (WIDTH=32): directed vectors with literal expectations, plus a
// reference model feeding an expected queue that is compared on every valid output cycle.
module tb_pipelined_alu;

  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [3:0]  control;
  logic        carryout, overflow, zero, err, dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [35:0] exp_q[$];

  pipelined_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .control(control), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carryout(carryout), .overflow(overflow), .zero(zero), .err(err),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model: {result, carryout, overflow, zero, err} ----------------
  function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic [3:0] c);
    logic [32:0] s;
    logic [31:0] r;
    logic        co, ov, er;
    longint      p;
    r = '0; co = 1'b0; ov = 1'b0; er = 1'b0;
    case (c)
      4'd0: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[31:0]; co = s[32];
        ov = (x[31] == y[31]) && (r[31] != x[31]);
      end
      4'd1: begin
        s = {1'b0, x} + {1'b0, ~y} + 33'd1;
        r = s[31:0]; co = s[32];
        ov = (x[31] != y[31]) && (r[31] != x[31]);
      end
      4'd2:  r = x ^ y;
      4'd3:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd4:  r = x & y;
      4'd5:  r = ~(x & y);
      4'd6:  r = ~(x | y);
      4'd7:  r = x | y;
      4'd8:  r = x << y[4:0];
      4'd9:  r = x >> y[4:0];
      4'd10: r = $signed(x) >>> y[4:0];
      4'd11: begin
        p  = longint'($signed(x)) * longint'($signed(y));
        r  = p[31:0];
        ov = (p != longint'($signed(r)));
      end
      default: er = 1'b1;
    endcase
    return {r, co, ov, (r == 32'd0), er};
  endfunction

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) chk("sb_spurious_out_valid", out_valid, 0);
        else begin
          chk("sb_out", {result, carryout, overflow, zero, err}, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, control));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] ta, input logic [31:0] tb_, input logic [3:0] tc);
    int guard;
    @(posedge clk); #1;
    a = ta; b = tb_; control = tc; in_valid = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Latency counts the negedges after the accepting edge until out_valid is seen.
  task automatic run_op(input string name, input logic [31:0] ta, input logic [31:0] tb_,
                        input logic [3:0] tc, input int exp_lat, input logic [31:0] exp_res,
                        input logic [3:0] exp_flags);
    int   lat;
    logic busy_ready;
    send(ta, tb_, tc);
    lat = 0;
    busy_ready = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid && in_ready) busy_ready = 1'b1;
    end while (!out_valid && lat < 100);
    chk($sformatf("%s_latency", name), lat, exp_lat);
    chk($sformatf("%s_result", name), result, exp_res);
    chk($sformatf("%s_flags", name), {carryout, overflow, zero, err}, exp_flags);
    if (exp_lat > 1) chk($sformatf("%s_in_ready_busy", name), busy_ready, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; control = '0;

    // model pins (hand-computed)
    chk("model_sub_ovf", model(32'h7FFFFFFF, 32'hFFFFFFFF, 4'd1), {32'h80000000, 4'b0100});
    chk("model_mul_7x-3", model(32'd7, 32'hFFFFFFFD, 4'd11), {32'hFFFFFFEB, 4'b0000});
    chk("model_mul_min_x_-1", model(32'h80000000, 32'hFFFFFFFF, 4'd11), {32'h80000000, 4'b0100});
    chk("model_slt", model(32'hFFFFFFFB, 32'd1, 4'd3), {32'd1, 4'b0000});

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {carryout, overflow, zero, err}, 4'b0000);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_state", dbg_state, 0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // single-cycle ops, {carryout, overflow, zero, err}
    run_op("add_1_m5",    32'd1,        32'hFFFFFFFB, 4'd0, 1, 32'hFFFFFFFC, 4'b0000);
    run_op("sub_ovf",     32'h7FFFFFFF, 32'hFFFFFFFF, 4'd1, 1, 32'h80000000, 4'b0100);
    run_op("add_carry",   32'hFFFFFFFF, 32'd1,        4'd0, 1, 32'h00000000, 4'b1010);
    run_op("sub_noborrow",32'd5,        32'd3,        4'd1, 1, 32'h00000002, 4'b1000);
    run_op("slt_1_m5",    32'd1,        32'hFFFFFFFB, 4'd3, 1, 32'h00000000, 4'b0010);
    run_op("slt_m5_1",    32'hFFFFFFFB, 32'd1,        4'd3, 1, 32'h00000001, 4'b0000);
    run_op("sra",         32'h80000000, 32'd4,        4'd10, 1, 32'hF8000000, 4'b0000);
    run_op("srl",         32'h80000000, 32'd4,        4'd9, 1, 32'h08000000, 4'b0000);
    run_op("sll_amt5",    32'd1,        32'h25,       4'd8, 1, 32'h00000020, 4'b0000);
    run_op("xor",         32'hFFFF0000, 32'h0F0F0F0F, 4'd2, 1, 32'hF0F00F0F, 4'b0000);
    run_op("nand",        32'hFFFFFFFF, 32'hFFFFFFFF, 4'd5, 1, 32'h00000000, 4'b0010);
    run_op("nor",         32'h00000000, 32'h00000000, 4'd6, 1, 32'hFFFFFFFF, 4'b0000);

    // back-pressure: hold AND result, present OR that must wait
    @(posedge clk); #1 out_ready = 1'b0;
    run_op("and_bp", 32'hF0F01234, 32'h0FF0FFFF, 4'd4, 1, 32'h00F01234, 4'b0000);
    @(posedge clk); #1;
    a = 32'h000000F0; b = 32'h0000000F; control = 4'd7; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_out_valid_held", out_valid, 1);
      chk("bp_hold", {result, carryout, overflow, zero, err}, {32'h00F01234, 4'b0000});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_on_drain", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_result", result, 32'h000000FF);

    // multiply
    run_op("mul_7_m3",    32'd7,        32'hFFFFFFFD, 4'd11, 33, 32'hFFFFFFEB, 4'b0000);
    run_op("mul_2p16sq",  32'h00010000, 32'h00010000, 4'd11, 33, 32'h00000000, 4'b0110);
    run_op("mul_min_x_1", 32'h80000000, 32'd1,        4'd11, 33, 32'h80000000, 4'b0000);
    run_op("mul_min_x_m1",32'h80000000, 32'hFFFFFFFF, 4'd11, 33, 32'h80000000, 4'b0100);

    // reset 10 cycles into a multiply
    send(32'd7, 32'hFFFFFFFD, 4'd11);
    repeat (10) @(negedge clk);
    chk("mid_mul_state", dbg_state, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_result", result, 0);
    chk("async_rst_in_ready", in_ready, 0);
    chk("async_rst_state", dbg_state, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);
    chk("rel_no_stale_valid", out_valid, 0);
    run_op("add_2_3", 32'd2, 32'd3, 4'd0, 1, 32'd5, 4'b0000);
    run_op("illegal", 32'h12345678, 32'h9ABCDEF0, 4'b1110, 1, 32'd0, 4'b0011);

    @(posedge clk); #1;
    @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipelined_alu.md
Name: pipelined_alu

Overview:
- Parametrised, registered successor to the team's 32-bit combinational ALU.
- Keeps the eight existing operations: ADD, SUB, XOR, SLT, AND, NAND, NOR, OR.
- Adds logical/arithmetic shifts and an iterative signed multiply.
- Valid/ready handshakes on input and output so it can sit between a decode stage and a writeback stage of the datapath.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥4 and a power of two.
- SHAMT_W, $clog2(WIDTH), number of low bits of b used as shift amount.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and control are presented
- in_ready  output  1  block can accept an operation this cycle
- a  input  WIDTH  operand A, two's complement
- b  input  WIDTH  operand B, two's complement; low SHAMT_W bits are the shift amount
- control  input  4  operation select
- out_valid  output  1  result and flags are valid
- out_ready  input  1  consumer takes the result this cycle
- result  output  WIDTH  operation result
- carryout  output  1  adder carry-out (ADD/SUB only)
- overflow  output  1  signed overflow (ADD/SUB/MUL)
- zero  output  1  result == 0
- err  output  1  illegal control code

Behaviour:
- Control encoding:
  - 0000 ADD, 0001 SUB, 0010 XOR, 0011 SLT, 0100 AND, 0101 NAND, 0110 NOR, 0111 OR
  - 1000 SLL, 1001 SRL, 1010 SRA, 1011 MUL
  - 1100–1111 illegal.
- Reset (async, rst_n=0): state IDLE; out_valid=0; result=0; carryout=0; overflow=0; zero=0; err=0. in_ready=0 while rst_n=0, and 1 from the first cycle after release.
- Reset asserted mid-MUL aborts the multiply. No result is produced.
- Accept condition: in_valid && in_ready at a rising edge. a, b and control are captured only then; they are ignored at all other times.
- in_ready = (state==IDLE) && (!out_valid || out_ready). A single-cycle op may be accepted in the same cycle the previous result drains.
- Single-cycle ops (all except MUL):
  - Result and flags registered on the edge that accepts the op.
  - out_valid=1 the following cycle: latency 1, throughput 1/cycle.
- Output hold: result and all flags are held stable while out_valid && !out_ready. out_valid drops on the edge where out_ready=1, unless a new op is accepted on that same edge.
- State machine: IDLE, MUL_RUN.
  - IDLE→MUL_RUN when a MUL is accepted. out_valid clears if the previous result was drained on that edge.
  - MUL_RUN takes exactly WIDTH cycles: unsigned shift-add on the operand magnitudes, one bit per cycle, sign applied on completion.
  - MUL_RUN→IDLE on its final cycle. The result is registered and out_valid=1, for a total latency of WIDTH+1 cycles from accept.
  - in_ready=0 throughout MUL_RUN.
- ADD/SUB:
  - SUB computes a + ~b + 1.
  - carryout = carry out of bit WIDTH-1, so SUB carryout=1 means no borrow.
  - overflow = carry into MSB XOR carry out of MSB.
- SLT: result = {WIDTH-1 zeros, (sub_msb XOR sub_overflow)}; carryout=0; overflow=0.
- Logic ops (XOR/AND/NAND/NOR/OR): bitwise; carryout=0; overflow=0.
- Shifts:
  - Amount is b[SHAMT_W-1:0]; upper bits of b are ignored.
  - SRA replicates a[WIDTH-1].
  - carryout=0; overflow=0.
- MUL:
  - result = low WIDTH bits of signed a*b.
  - overflow=1 iff the full 2*WIDTH signed product is not the sign extension of result.
  - carryout=0.
  - Most-negative operand magnitudes must be handled: −2^(W-1) × 1 gives no overflow; −2^(W-1) × −1 gives overflow.
- Illegal code: accepted with latency 1; result=0; zero=1; err=1; other flags 0.
- zero = (result==0) for every op. err=0 for every legal op.

Test Plan:
- WIDTH=32, ADD a=1, b=-5 → one cycle later out_valid=1, result=0xFFFFFFFC, carryout=0, overflow=0, zero=0. Then SUB a=0x7FFFFFFF, b=0xFFFFFFFF → result=0x80000000, overflow=1.
- SLT a=1, b=-5 → result=0. SLT a=-5, b=1 → result=1. SRA a=0x80000000, b=4 → 0xF8000000. SRL of the same → 0x08000000. SLL a=1, b=0x25 → 0x20 (shift amount 5).
- Back-pressure: out_ready=0 for 5 cycles after an AND result appears. Require in_ready=0 and result/flags stable throughout. Raise out_ready with a new in_valid → new op accepted on the same edge, next result valid the cycle after.
- MUL a=7, b=-3 → in_ready=0 for 32 cycles, out_valid rises exactly 33 cycles after accept, result=0xFFFFFFEB, overflow=0. MUL 0x00010000 × 0x00010000 → result=0, zero=1, overflow=1.
- MUL 0x80000000 × 1 → 0x80000000, overflow=0. MUL 0x80000000 × -1 → 0x80000000, overflow=1.
- Pull rst_n low 10 cycles into a MUL → outputs clear immediately (async). After release: no stale out_valid, in_ready=1, and a following ADD 2+3 → 5. Control=1110 → result=0, zero=1, err=1.
